// File: rtl/power_seq.sv
// Power-rail sequencer: brings rails up in order with per-rail power-good
// supervision, takes them down in reverse order, and latches sequencing faults.
module power_seq #(
    parameter int         NUM_RAILS  = 4,
    parameter logic [7:0] PG_TIMEOUT = 8'd20,
    parameter logic [3:0] RAIL_DELAY = 4'd2,
    parameter logic [3:0] OFF_DELAY  = 4'd2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce_1khz,
    input  logic                 pwr_enable,
    input  logic [NUM_RAILS-1:0] pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 pwr_good,
    output logic                 fault,
    output logic [2:0]           fault_rail
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_RAILS - 1);

    state_t                 state_r;
    logic [2:0]             idx_r;
    logic [7:0]             cnt_r;
    logic [NUM_RAILS-1:0]   rail_en_r;
    logic                   pwr_good_r;
    logic                   fault_r;
    logic [2:0]             fault_rail_r;

    logic [3:0]             lt_fail_s;
    logic [3:0]             le_fail_s;
    logic                   pg_cur_s;
    logic                   pg_to_s;
    logic                   settle_done_s;
    logic                   off_done_s;

    function automatic logic [NUM_RAILS-1:0] onehot(input logic [2:0] i);
        logic [NUM_RAILS-1:0] v;
        for (int k = 0; k < NUM_RAILS; k++) begin
            v[k] = (3'(k) == i);
        end
        return v;
    endfunction

    // Returns {hit, index} of the lowest rail below lim (or at lim when incl) whose pg is low.
    function automatic logic [3:0] find_fail(input logic [NUM_RAILS-1:0] pg_v,
                                             input logic [2:0] lim,
                                             input logic incl);
        logic [3:0] res;
        res = 4'd0;
        for (int k = NUM_RAILS - 1; k >= 0; k--) begin
            if (!pg_v[k] && ((3'(k) < lim) || (incl && (3'(k) == lim)))) begin
                res = {1'b1, 3'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // An N-tick wait ends on the strobe that brings the count to N.
    function automatic logic wait_done(input logic [7:0] cnt, input logic [7:0] n);
        return (({1'b0, cnt} + 9'd1) >= {1'b0, n});
    endfunction

    assign lt_fail_s     = find_fail(pg, idx_r, 1'b0);
    assign le_fail_s     = find_fail(pg, idx_r, 1'b1);
    assign pg_cur_s      = |(pg & onehot(idx_r));
    assign pg_to_s       = ce_1khz && wait_done(cnt_r, PG_TIMEOUT);
    assign settle_done_s = ce_1khz && wait_done(cnt_r, {4'd0, RAIL_DELAY});
    assign off_done_s    = ce_1khz && wait_done(cnt_r, {4'd0, OFF_DELAY});

    // Sequencer FSM with registered outputs; every transition or rail step restarts the delay counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_OFF;
            idx_r        <= 3'd0;
            cnt_r        <= 8'd0;
            rail_en_r    <= {NUM_RAILS{1'b0}};
            pwr_good_r   <= 1'b0;
            fault_r      <= 1'b0;
            fault_rail_r <= 3'd0;
        end else begin
            if (ce_1khz && (cnt_r != 8'hFF)) begin
                cnt_r <= cnt_r + 8'd1;
            end
            case (state_r)
                ST_OFF: begin
                    rail_en_r  <= {NUM_RAILS{1'b0}};
                    pwr_good_r <= 1'b0;
                    idx_r      <= 3'd0;
                    if (pwr_enable) begin
                        state_r      <= ST_RAMP_UP;
                        rail_en_r    <= onehot(3'd0);
                        fault_r      <= 1'b0;
                        fault_rail_r <= 3'd0;
                        cnt_r        <= 8'd0;
                    end
                end
                ST_RAMP_UP, ST_SETTLE, ST_ON: begin
                    if (!pwr_enable) begin
                        state_r    <= ST_RAMP_DOWN;
                        rail_en_r  <= rail_en_r & ~onehot(idx_r);
                        pwr_good_r <= 1'b0;
                        cnt_r      <= 8'd0;
                    end else if ((state_r == ST_RAMP_UP) ? lt_fail_s[3] : le_fail_s[3]) begin
                        state_r      <= ST_FAULT;
                        rail_en_r    <= {NUM_RAILS{1'b0}};
                        pwr_good_r   <= 1'b0;
                        fault_r      <= 1'b1;
                        fault_rail_r <= (state_r == ST_RAMP_UP) ? lt_fail_s[2:0] : le_fail_s[2:0];
                        cnt_r        <= 8'd0;
                    end else if (state_r == ST_RAMP_UP) begin
                        // pg is checked before the timeout so a coincident pg wins.
                        if (pg_cur_s) begin
                            state_r <= ST_SETTLE;
                            cnt_r   <= 8'd0;
                        end else if (pg_to_s) begin
                            state_r      <= ST_FAULT;
                            rail_en_r    <= {NUM_RAILS{1'b0}};
                            fault_r      <= 1'b1;
                            fault_rail_r <= idx_r;
                            cnt_r        <= 8'd0;
                        end
                    end else if (state_r == ST_SETTLE) begin
                        if (settle_done_s) begin
                            cnt_r <= 8'd0;
                            if (idx_r == LAST_IDX) begin
                                state_r    <= ST_ON;
                                pwr_good_r <= 1'b1;
                            end else begin
                                state_r   <= ST_RAMP_UP;
                                idx_r     <= idx_r + 3'd1;
                                rail_en_r <= rail_en_r | onehot(idx_r + 3'd1);
                            end
                        end
                    end else begin
                        rail_en_r  <= {NUM_RAILS{1'b1}};
                        pwr_good_r <= 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    pwr_good_r <= 1'b0;
                    if (off_done_s) begin
                        cnt_r <= 8'd0;
                        if (idx_r == 3'd0) begin
                            state_r <= ST_OFF;
                        end else begin
                            idx_r     <= idx_r - 3'd1;
                            rail_en_r <= rail_en_r & ~onehot(idx_r - 3'd1);
                        end
                    end
                end
                ST_FAULT: begin
                    rail_en_r  <= {NUM_RAILS{1'b0}};
                    pwr_good_r <= 1'b0;
                    fault_r    <= 1'b1;
                    if (!pwr_enable) begin
                        state_r <= ST_OFF;
                        idx_r   <= 3'd0;
                        cnt_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r    <= ST_OFF;
                    idx_r      <= 3'd0;
                    cnt_r      <= 8'd0;
                    rail_en_r  <= {NUM_RAILS{1'b0}};
                    pwr_good_r <= 1'b0;
                end
            endcase
        end
    end

    assign rail_en    = rail_en_r;
    assign pwr_good   = pwr_good_r;
    assign fault      = fault_r;
    assign fault_rail = fault_rail_r;

endmodule

// File: tb/tb_power_seq.sv
// Directed bench for power_seq: vector table for a full up/down cycle plus
// hand-written timeout, brown-out, abort and reset sequences.
module tb_power_seq;

    logic       clk;
    logic       rst_n;
    logic       ce_1khz;
    logic       pwr_enable;
    logic [3:0] pg;
    logic [3:0] rail_en;
    logic       pwr_good;
    logic       fault;
    logic [2:0] fault_rail;

    int checks;
    int errors;

    power_seq #(
        .NUM_RAILS (4),
        .PG_TIMEOUT(8'd20),
        .RAIL_DELAY(4'd2),
        .OFF_DELAY (4'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_1khz   (ce_1khz),
        .pwr_enable(pwr_enable),
        .pg        (pg),
        .rail_en   (rail_en),
        .pwr_good  (pwr_good),
        .fault     (fault),
        .fault_rail(fault_rail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pe;
        logic [3:0] pg;
        logic       ce;
        logic [3:0] rail;
        logic       good;
        logic       flt;
        logic [2:0] frail;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic pe_v, input logic [3:0] pg_v, input logic ce_v,
                                input logic [3:0] rail_v, input logic good_v);
        vec_t v;
        v.pe = pe_v; v.pg = pg_v; v.ce = ce_v;
        v.rail = rail_v; v.good = good_v; v.flt = 1'b0; v.frail = 3'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] r, input logic g,
                           input logic f, input logic [2:0] fr);
        chk({name, "_rail"}, {4'd0, rail_en}, {4'd0, r});
        chk({name, "_good"}, {7'd0, pwr_good}, {7'd0, g});
        chk({name, "_fault"}, {7'd0, fault}, {7'd0, f});
        chk({name, "_frail"}, {5'd0, fault_rail}, {5'd0, fr});
    endtask

    task automatic cyc(input logic c);
        ce_1khz = c;
        @(posedge clk);
        #1;
        ce_1khz = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b0);
        cyc(1'b1);
    endtask

    // From OFF: request power and bring rails 0..n-1 to power-good, n settles done.
    task automatic ramp_to(input int n);
        pg = 4'b0000;
        pwr_enable = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < n; i++) begin
            pg = pg | (4'b0001 << i);
            cyc(1'b0);
            tick();
            tick();
        end
    endtask

    task automatic go_off();
        pwr_enable = 1'b0;
        cyc(1'b0);
        repeat (10) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ce_1khz = 1'b0;
        pwr_enable = 1'b0;
        pg = 4'b0000;

        vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);
        vecs[1]  = mk(1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0);
        vecs[2]  = mk(1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0);
        vecs[3]  = mk(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0);
        vecs[4]  = mk(1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0);
        vecs[5]  = mk(1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0);
        vecs[6]  = mk(1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0);
        vecs[7]  = mk(1'b1, 4'b0011, 1'b1, 4'b0011, 1'b0);
        vecs[8]  = mk(1'b1, 4'b0011, 1'b1, 4'b0111, 1'b0);
        vecs[9]  = mk(1'b1, 4'b0011, 1'b1, 4'b0111, 1'b0);
        vecs[10] = mk(1'b1, 4'b0011, 1'b1, 4'b0111, 1'b0);
        vecs[11] = mk(1'b1, 4'b0111, 1'b1, 4'b0111, 1'b0);
        vecs[12] = mk(1'b1, 4'b0111, 1'b1, 4'b1111, 1'b0);
        vecs[13] = mk(1'b1, 4'b0111, 1'b1, 4'b1111, 1'b0);
        vecs[14] = mk(1'b1, 4'b0111, 1'b1, 4'b1111, 1'b0);
        vecs[15] = mk(1'b1, 4'b1111, 1'b1, 4'b1111, 1'b0);
        vecs[16] = mk(1'b1, 4'b1111, 1'b1, 4'b1111, 1'b1);
        vecs[17] = mk(1'b1, 4'b1111, 1'b1, 4'b1111, 1'b1);
        vecs[18] = mk(1'b0, 4'b1111, 1'b0, 4'b0111, 1'b0);
        vecs[19] = mk(1'b0, 4'b0111, 1'b1, 4'b0111, 1'b0);
        vecs[20] = mk(1'b0, 4'b0111, 1'b1, 4'b0011, 1'b0);
        vecs[21] = mk(1'b0, 4'b0011, 1'b1, 4'b0011, 1'b0);
        vecs[22] = mk(1'b0, 4'b0011, 1'b1, 4'b0001, 1'b0);
        vecs[23] = mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0);
        vecs[24] = mk(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0);
        vecs[25] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        vecs[26] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        vecs[27] = mk(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Normal power-up to ON and reverse power-down, one row per tick
        for (int i = 0; i < 28; i++) begin
            pwr_enable = vecs[i].pe;
            pg = vecs[i].pg;
            cyc(1'b0);
            cyc(vecs[i].ce);
            chk_all($sformatf("vec%0d", i), vecs[i].rail, vecs[i].good, vecs[i].flt, vecs[i].frail);
        end
        go_off();
        chk_all("off1", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Timeout on rail 2: fault on the 20th tick
        ramp_to(2);
        chk_all("to_idx2", 4'b0111, 1'b0, 1'b0, 3'd0);
        repeat (19) tick();
        chk_all("to_19", 4'b0111, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("to_20", 4'b0000, 1'b0, 1'b1, 3'd2);
        repeat (3) tick();
        chk_all("to_hold", 4'b0000, 1'b0, 1'b1, 3'd2);
        pwr_enable = 1'b0;
        cyc(1'b0);
        chk_all("to_off", 4'b0000, 1'b0, 1'b1, 3'd2);
        pwr_enable = 1'b1;
        pg = 4'b0000;
        cyc(1'b0);
        chk_all("to_restart", 4'b0001, 1'b0, 1'b0, 3'd0);

        // pg coinciding with the timeout strobe wins
        repeat (19) tick();
        cyc(1'b0);
        pg = 4'b0001;
        cyc(1'b1);
        chk_all("pgwin", 4'b0001, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        chk_all("pgwin_next", 4'b0011, 1'b0, 1'b0, 3'd0);
        go_off();
        chk_all("off2", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Brown-out in ON: rails 1 and 2 drop, lowest reported
        ramp_to(4);
        chk_all("on", 4'b1111, 1'b1, 1'b0, 3'd0);
        pg = 4'b1001;
        cyc(1'b0);
        chk_all("brownout", 4'b0000, 1'b0, 1'b1, 3'd1);
        go_off();
        chk_all("off3", 4'b0000, 1'b0, 1'b1, 3'd1);

        // pwr_enable drop beats a simultaneous pg fault
        ramp_to(4);
        pwr_enable = 1'b0;
        pg = 4'b1101;
        cyc(1'b0);
        chk_all("prio", 4'b0111, 1'b0, 1'b0, 3'd0);
        repeat (10) tick();
        chk_all("off4", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Abort in SETTLE idx=1, re-request ignored until OFF
        ramp_to(1);
        pg = 4'b0011;
        cyc(1'b0);
        pwr_enable = 1'b0;
        cyc(1'b0);
        chk_all("abort", 4'b0001, 1'b0, 1'b0, 3'd0);
        pwr_enable = 1'b1;
        tick();
        chk_all("abort_t1", 4'b0001, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("abort_t2", 4'b0000, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("abort_t3", 4'b0000, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("abort_t4", 4'b0000, 1'b0, 1'b0, 3'd0);
        cyc(1'b0);
        chk_all("abort_restart", 4'b0001, 1'b0, 1'b0, 3'd0);
        go_off();

        // Asynchronous reset mid-ramp, then restart on the first edge
        ramp_to(1);
        chk_all("pre_rst", 4'b0011, 1'b0, 1'b0, 3'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 1'b0, 1'b0, 3'd0);
        #1;
        rst_n = 1'b1;
        pg = 4'b0000;
        cyc(1'b0);
        chk_all("post_rst", 4'b0001, 1'b0, 1'b0, 3'd0);
        go_off();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_seq.md
POWER_SEQ -- requirements
Module: power_seq

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 4, number of sequenced rails (2..8).
REQ-002 SHALL have parameter PG_TIMEOUT, default 8'd20, ce_1khz ticks allowed for a rail's power-good.
REQ-003 SHALL have parameter RAIL_DELAY, default 4'd2, ce_1khz ticks of settle time after each rail's power-good.
REQ-004 SHALL have parameter OFF_DELAY, default 4'd2, ce_1khz ticks between successive rail turn-offs.
REQ-005 clk  input  1  system clock; the block's only clock.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 ce_1khz  input  1  single-cycle clock-enable strobe at 1 kHz.
REQ-008 pwr_enable  input  1  power request from the power-button FSM; high = on.
REQ-009 pg  input  NUM_RAILS  per-rail power-good, already synchronised to clk.
REQ-010 rail_en  output  NUM_RAILS  per-rail enable, registered.
REQ-011 pwr_good  output  1  high only in ON, registered.
REQ-012 fault  output  1  latched sequencing fault, registered.
REQ-013 fault_rail  output  3  index of the failing rail, valid while fault is high.

Function
REQ-014 SHALL implement states OFF, RAMP_UP, SETTLE, ON, RAMP_DOWN, FAULT, plus a rail index idx and one delay counter.
REQ-015 Delay counter SHALL clear on every state entry and increment only on ce_1khz; an "N-tick wait" ends on the N-th ce_1khz strobe after entry.
REQ-016 All outputs SHALL update on the clk edge that enters the new state (no extra latency).
REQ-017 OFF: rail_en=0, pwr_good=0; on pwr_enable=1 -> idx=0, rail_en[0]=1, fault cleared, go RAMP_UP.
REQ-018 RAMP_UP: pg[idx]=1 -> SETTLE; PG_TIMEOUT-tick wait elapsed without pg[idx] -> FAULT with fault_rail=idx; pg wins if both occur in the same cycle.
REQ-019 SETTLE: after RAIL_DELAY ticks, idx=NUM_RAILS-1 -> ON, else idx+1, set rail_en[idx+1], go RAMP_UP.
REQ-020 ON: pwr_good=1, rail_en all ones.
REQ-021 In RAMP_UP, SETTLE and ON, any pg[i]=0 with i < idx (or i=idx in SETTLE/ON) SHALL go FAULT with fault_rail = lowest such i.
REQ-022 In RAMP_UP, SETTLE and ON, pwr_enable=0 SHALL go RAMP_DOWN keeping current idx; pwr_enable takes priority over a simultaneous pg fault.
REQ-023 RAMP_DOWN: on entry clear rail_en[idx]; after OFF_DELAY ticks, idx=0 -> OFF, else idx-1 and clear rail_en[idx-1]; strict reverse order.
REQ-024 pwr_enable re-asserted during RAMP_DOWN SHALL be ignored until OFF is reached; OFF then restarts the sequence.
REQ-025 FAULT: rail_en=0 at once (all rails simultaneously), pwr_good=0, fault=1; leave to OFF only when pwr_enable=0; fault and fault_rail held until the next OFF->RAMP_UP.
REQ-026 The counter SHALL saturate rather than wrap; idx SHALL never exceed NUM_RAILS-1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force OFF, idx=0, counter=0, rail_en=0, pwr_good=0, fault=0, fault_rail=0, including mid-sequence.
REQ-028 After rst_n rises the block SHALL evaluate pwr_enable on the first clk edge.

Verification
REQ-029 Normal up: pwr_enable=1, each pg[i] rises 3 ticks after rail_en[i] -> rail_en 0001,0011,0111,1111 in order, each rail 2 ticks after previous pg, pwr_good=1.
REQ-030 Timeout: pg[2] never rises -> on 20th tick in RAMP_UP idx=2, fault=1, fault_rail=2, rail_en=0000; drop pwr_enable -> OFF, fault stays 1 until next request.
REQ-031 Power down: from ON drop pwr_enable -> rail_en 0111,0011,0001,0000, 2 ticks apart, pwr_good=0 on first edge.
REQ-032 Brown-out: in ON force pg[1]=0 -> next edge FAULT, fault_rail=1, rail_en=0000.
REQ-033 Abort: drop pwr_enable in SETTLE idx=1 -> rail_en 0001 then 0000 after 2 ticks; re-raise during ramp-down -> restart only after OFF.
REQ-034 Reset mid-ramp: rst_n=0 with rail_en=0011 -> all outputs 0 without a clk edge.
